// File: rtl/axis_ft245_device_pkg.sv
// Shared definitions for the FT245 device model: FSM encodings, strobe indices and sampling depth.
// Define AXIS_FT245_DEVICE_SYNC_EN to add a 2-flop synchronizer ahead of strobe/data sampling.
package axis_ft245_device_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACTIVE,
        RD_RECOVER
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_RECOVER
    } wr_state_t;

    // Inactive level of the active-low bus strobes.
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int STROBE_COUNT = 3;
    localparam int STB_RD       = 0;
    localparam int STB_WR       = 1;
    localparam int STB_SIWU     = 2;

`ifdef AXIS_FT245_DEVICE_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    localparam int SAMPLE_DEPTH = SYNC_STAGES + 1;

endpackage

// File: rtl/ft245_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head and registered full/empty flags.
module ft245_byte_fifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] push_data,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full FIFO is allowed when the same cycle frees a slot.
    assign do_pop     = pop && !empty_reg;
    assign do_push    = push && (!full_reg || do_pop);
    assign count_next = count_reg + (ADDR_WIDTH + 1)'(do_push) - (ADDR_WIDTH + 1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == (ADDR_WIDTH + 1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/axis_ft245_device.sv
// FT245 FIFO-chip device model: AXI-stream on the USB side, rd_n/wr_n strobe responder on the bus side.
// Define AXIS_FT245_DEVICE_SYNC_EN to pass strobes and d_in through a 2-flop synchronizer first.
module axis_ft245_device
    import axis_ft245_device_pkg::*;
#(
    parameter int RX_ADDR_WIDTH       = 4,
    parameter int TX_ADDR_WIDTH       = 4,
    parameter int RXF_INACTIVE_CYCLES = 2,
    parameter int TXE_INACTIVE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ft245_d_in,
    output logic [7:0] ft245_d_out,
    output logic       ft245_d_oe,
    input  logic       ft245_rd_n,
    input  logic       ft245_wr_n,
    output logic       ft245_rxf_n,
    output logic       ft245_txe_n,
    input  logic       ft245_siwu_n,
    input  logic [7:0] input_axis_tdata,
    input  logic       input_axis_tvalid,
    output logic       input_axis_tready,
    output logic [7:0] output_axis_tdata,
    output logic       output_axis_tvalid,
    input  logic       output_axis_tready,
    output logic       send_immediate,
    output logic       rd_underflow,
    output logic       wr_overflow
);

    logic [STROBE_COUNT-1:0] strobe_pipe_reg [SAMPLE_DEPTH];
    logic [7:0]              din_pipe_reg    [SAMPLE_DEPTH];
    logic [STROBE_COUNT-1:0] strobe_prev_reg;
    logic [STROBE_COUNT-1:0] strobe_s;
    logic [STROBE_COUNT-1:0] strobe_fall;
    logic [STROBE_COUNT-1:0] strobe_rise;
    logic [7:0]              din_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SAMPLE_DEPTH; i++) begin
                strobe_pipe_reg[i] <= {STROBE_COUNT{IDLE_LEVEL}};
                din_pipe_reg[i]    <= 8'h00;
            end
            strobe_prev_reg <= {STROBE_COUNT{IDLE_LEVEL}};
        end else begin
            strobe_pipe_reg[0] <= {ft245_siwu_n, ft245_wr_n, ft245_rd_n};
            din_pipe_reg[0]    <= ft245_d_in;
            for (int i = 1; i < SAMPLE_DEPTH; i++) begin
                strobe_pipe_reg[i] <= strobe_pipe_reg[i-1];
                din_pipe_reg[i]    <= din_pipe_reg[i-1];
            end
            strobe_prev_reg <= strobe_s;
        end
    end

    assign strobe_s = strobe_pipe_reg[SAMPLE_DEPTH-1];
    assign din_s    = din_pipe_reg[SAMPLE_DEPTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < STROBE_COUNT; gi++) begin : g_edge
            assign strobe_fall[gi] = (strobe_prev_reg[gi] == IDLE_LEVEL) && (strobe_s[gi] != IDLE_LEVEL);
            assign strobe_rise[gi] = (strobe_prev_reg[gi] != IDLE_LEVEL) && (strobe_s[gi] == IDLE_LEVEL);
        end
    endgenerate

    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_push;
    logic       rx_pop;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_push;
    logic       tx_pop;
    logic       ready_armed_reg;

    assign rx_push = input_axis_tvalid && input_axis_tready;
    assign tx_pop  = output_axis_tvalid && output_axis_tready;

    ft245_byte_fifo #(.ADDR_WIDTH(RX_ADDR_WIDTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_data (input_axis_tdata),
        .push      (rx_push),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    ft245_byte_fifo #(.ADDR_WIDTH(TX_ADDR_WIDTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_data (din_s),
        .push      (tx_push),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    rd_state_t  rd_state_reg, rd_state_next;
    wr_state_t  wr_state_reg, wr_state_next;
    logic [7:0] rd_cnt_reg, rd_cnt_next;
    logic [7:0] wr_cnt_reg, wr_cnt_next;
    logic       rd_uf_reg, rd_uf_next;
    logic       underflow_reg, underflow_next;
    logic       overflow_reg, overflow_next;
    logic       siwu_reg;
    logic       rxf_int;
    logic       txe_int;

    assign rxf_int = (rd_state_reg != RD_IDLE) || rx_empty;
    assign txe_int = (wr_state_reg != WR_IDLE) || tx_full;

    // A fall seen while rxf_n is high starts a dummy read: bus shows 0x00 and nothing is popped.
    always_comb begin
        rd_state_next  = rd_state_reg;
        rd_cnt_next    = rd_cnt_reg;
        rd_uf_next     = rd_uf_reg;
        rx_pop         = 1'b0;
        underflow_next = 1'b0;
        case (rd_state_reg)
            RD_IDLE, RD_RECOVER: begin
                if (strobe_fall[STB_RD]) begin
                    rd_state_next  = RD_ACTIVE;
                    rd_uf_next     = rxf_int;
                    underflow_next = rxf_int;
                end else if (rd_state_reg == RD_RECOVER) begin
                    if (rd_cnt_reg <= 8'd1) begin
                        rd_state_next = RD_IDLE;
                    end else begin
                        rd_cnt_next = rd_cnt_reg - 8'd1;
                    end
                end
            end
            RD_ACTIVE: begin
                if (strobe_rise[STB_RD]) begin
                    rx_pop      = !rd_uf_reg;
                    rd_cnt_next = 8'(RXF_INACTIVE_CYCLES);
                    rd_state_next = (RXF_INACTIVE_CYCLES == 0) ? RD_IDLE : RD_RECOVER;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_cnt_next   = wr_cnt_reg;
        tx_push       = 1'b0;
        overflow_next = 1'b0;
        case (wr_state_reg)
            WR_IDLE, WR_RECOVER: begin
                if (strobe_fall[STB_WR]) begin
                    wr_state_next = WR_ACTIVE;
                    tx_push       = 1'b1;
                    overflow_next = tx_full && !tx_pop;
                end else if (wr_state_reg == WR_RECOVER) begin
                    if (wr_cnt_reg <= 8'd1) begin
                        wr_state_next = WR_IDLE;
                    end else begin
                        wr_cnt_next = wr_cnt_reg - 8'd1;
                    end
                end
            end
            WR_ACTIVE: begin
                if (strobe_rise[STB_WR]) begin
                    wr_cnt_next   = 8'(TXE_INACTIVE_CYCLES);
                    wr_state_next = (TXE_INACTIVE_CYCLES == 0) ? WR_IDLE : WR_RECOVER;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_reg    <= RD_IDLE;
            wr_state_reg    <= WR_IDLE;
            rd_cnt_reg      <= 8'd0;
            wr_cnt_reg      <= 8'd0;
            rd_uf_reg       <= 1'b0;
            underflow_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
            siwu_reg        <= 1'b0;
            ready_armed_reg <= 1'b0;
        end else begin
            rd_state_reg    <= rd_state_next;
            wr_state_reg    <= wr_state_next;
            rd_cnt_reg      <= rd_cnt_next;
            wr_cnt_reg      <= wr_cnt_next;
            rd_uf_reg       <= rd_uf_next;
            underflow_reg   <= underflow_next;
            overflow_reg    <= overflow_next;
            siwu_reg        <= strobe_fall[STB_SIWU];
            ready_armed_reg <= 1'b1;
        end
    end

    // Bus-facing levels are forced idle while rst is held so d_oe drops within the reset cycle.
    assign ft245_d_oe         = !rst && (rd_state_reg == RD_ACTIVE);
    assign ft245_d_out        = (ft245_d_oe && !rd_uf_reg) ? rx_head : 8'h00;
    assign ft245_rxf_n        = rst || rxf_int;
    assign ft245_txe_n        = rst || txe_int;
    assign input_axis_tready  = ready_armed_reg && !rx_full;
    assign output_axis_tdata  = tx_head;
    assign output_axis_tvalid = !rst && !tx_empty;
    assign send_immediate     = siwu_reg;
    assign rd_underflow       = underflow_reg;
    assign wr_overflow        = overflow_reg;

endmodule

// File: tb/tb_axis_ft245_device.sv
// Directed-plus-random bench for axis_ft245_device with a queue-based model of both FIFOs.
`timescale 1ns/1ps
module tb_axis_ft245_device;

`ifdef AXIS_FT245_DEVICE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int TX_DEPTH = 16;
    localparam int BOUND    = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ft245_d_in = 8'h00;
    logic [7:0] ft245_d_out;
    logic       ft245_d_oe;
    logic       ft245_rd_n = 1'b1;
    logic       ft245_wr_n = 1'b1;
    logic       ft245_rxf_n;
    logic       ft245_txe_n;
    logic       ft245_siwu_n = 1'b1;
    logic [7:0] input_axis_tdata = 8'h00;
    logic       input_axis_tvalid = 1'b0;
    logic       input_axis_tready;
    logic [7:0] output_axis_tdata;
    logic       output_axis_tvalid;
    logic       output_axis_tready = 1'b0;
    logic       send_immediate;
    logic       rd_underflow;
    logic       wr_overflow;

    axis_ft245_device dut (
        .clk                (clk),
        .rst                (rst),
        .ft245_d_in         (ft245_d_in),
        .ft245_d_out        (ft245_d_out),
        .ft245_d_oe         (ft245_d_oe),
        .ft245_rd_n         (ft245_rd_n),
        .ft245_wr_n         (ft245_wr_n),
        .ft245_rxf_n        (ft245_rxf_n),
        .ft245_txe_n        (ft245_txe_n),
        .ft245_siwu_n       (ft245_siwu_n),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .send_immediate     (send_immediate),
        .rd_underflow       (rd_underflow),
        .wr_overflow        (wr_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: bytes waiting in RX, writes accepted into TX, and observed outputs.
    byte unsigned rx_model[$];
    byte unsigned got_q[$];
    byte unsigned exp_out[$];
    int tx_written = 0;
    int uf_seen = 0, ovf_seen = 0, si_seen = 0;

    always @(posedge clk) begin
        if (output_axis_tvalid === 1'b1 && output_axis_tready === 1'b1) got_q.push_back(output_axis_tdata);
        if (rd_underflow === 1'b1) uf_seen <= uf_seen + 1;
        if (wr_overflow === 1'b1) ovf_seen <= ovf_seen + 1;
        if (send_immediate === 1'b1) si_seen <= si_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_tx_model();
        got_q.delete();
        exp_out.delete();
        tx_written = 0;
    endtask

    task automatic wait_rxf_low(input string tag);
        int k = 0;
        while (ft245_rxf_n !== 1'b0 && k < BOUND) begin tick(); k++; end
        check(tag, (k >= BOUND), 0);
    endtask

    task automatic wait_txe_low(input string tag);
        int k = 0;
        while (ft245_txe_n !== 1'b0 && k < BOUND) begin tick(); k++; end
        check(tag, (k >= BOUND), 0);
    endtask

    task automatic push_in(input byte unsigned b);
        int k = 0;
        input_axis_tdata  = b;
        input_axis_tvalid = 1'b1;
        while (input_axis_tready !== 1'b1 && k < BOUND) begin tick(); k++; end
        check("push_timeout", (k >= BOUND), 0);
        tick();
        input_axis_tvalid = 1'b0;
        input_axis_tdata  = 8'h00;
        rx_model.push_back(b);
        $display("push   in  0x%02h  rx_model=%0d", b, rx_model.size());
    endtask

    // Full controller read strobe with timing checks on d_oe, d_out and rxf_n recovery.
    task automatic ctrl_read(input int hold);
        byte unsigned exp_d;
        bit           uf;
        uf    = (rx_model.size() == 0);
        exp_d = uf ? 8'h00 : rx_model[0];
        ft245_rd_n = 1'b0;
        tick(LAT - 1);
        check("rd_oe_early", ft245_d_oe, 0);
        tick();
        check("rd_oe", ft245_d_oe, 1);
        check("rd_data", ft245_d_out, exp_d);
        tick(hold);
        ft245_rd_n = 1'b1;
        if (!uf) void'(rx_model.pop_front());
        tick(LAT);
        check("rd_oe_release", ft245_d_oe, 0);
        check("rxf_recover0", ft245_rxf_n, 1);
        tick();
        check("rxf_recover1", ft245_rxf_n, 1);
        tick();
        check("rxf_idle", ft245_rxf_n, (rx_model.size() == 0) ? 1 : 0);
        $display("read   exp 0x%02h  underflow=%0d", exp_d, uf);
    endtask

    // Full controller write strobe; d_in is scrambled after capture to prove fall-sample capture.
    task automatic ctrl_write(input byte unsigned b, input int hold);
        bit accepted;
        accepted = ((tx_written - got_q.size()) < TX_DEPTH);
        if (accepted) tx_written++;
        ft245_d_in = b;
        ft245_wr_n = 1'b0;
        tick(LAT);
        check("txe_active", ft245_txe_n, 1);
        ft245_d_in = ~b;
        tick(hold);
        ft245_wr_n = 1'b1;
        tick(LAT);
        check("txe_recover0", ft245_txe_n, 1);
        tick();
        check("txe_recover1", ft245_txe_n, 1);
        tick();
        check("txe_idle", ft245_txe_n, ((tx_written - got_q.size()) >= TX_DEPTH) ? 1 : 0);
        $display("write  0x%02h  accepted=%0d", b, accepted);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_uf, base_ovf, base_si;
        byte unsigned b;

        // Reset state
        tick(3);
        check("rst_rxf_n", ft245_rxf_n, 1);
        check("rst_txe_n", ft245_txe_n, 1);
        check("rst_d_oe", ft245_d_oe, 0);
        check("rst_d_out", ft245_d_out, 8'h00);
        check("rst_out_tvalid", output_axis_tvalid, 0);
        check("rst_in_tready", input_axis_tready, 0);
        check("rst_pulses", {send_immediate, rd_underflow, wr_overflow}, 3'b000);
        rst = 1'b0;
        tick();
        check("post_rst_tready", input_axis_tready, 1);
        check("post_rst_rxf_n", ft245_rxf_n, 1);
        check("post_rst_txe_n", ft245_txe_n, 0);
        $display("reset  released");

        // 1: single byte USB -> controller
        push_in(8'h5A);
        check("t1_rxf_low", ft245_rxf_n, 0);
        wait_rxf_low("t1_wait_rxf");
        ctrl_read(8 - LAT);

        // 2: single controller write
        output_axis_tready = 1'b1;
        clear_tx_model();
        exp_out.push_back(8'hA5);
        wait_txe_low("t2_wait_txe");
        ctrl_write(8'hA5, 7 - LAT);
        tick(4);
        check("t2_count", got_q.size(), 1);
        check("t2_data", got_q.size() > 0 ? got_q[0] : 8'hxx, exp_out[0]);

        // 3: fill TX with random bytes, overflow once, drain in order
        output_axis_tready = 1'b0;
        clear_tx_model();
        base_ovf = ovf_seen;
        for (int i = 0; i < TX_DEPTH; i++) begin
            b = 8'($urandom);
            exp_out.push_back(b);
            wait_txe_low("t3_wait_txe");
            ctrl_write(b, $urandom_range(1, 4));
        end
        tick(3);
        check("t3_txe_full", ft245_txe_n, 1);
        ctrl_write(8'($urandom), 2);
        tick(2);
        check("t3_overflow", ovf_seen - base_ovf, 1);
        output_axis_tready = 1'b1;
        tick(TX_DEPTH + 6);
        check("t3_drain_count", got_q.size(), TX_DEPTH);
        for (int i = 0; i < TX_DEPTH && i < got_q.size(); i++) begin
            check("t3_drain_data", got_q[i], exp_out[i]);
        end
        check("t3_txe_free", ft245_txe_n, 0);

        // 4: read while RX empty
        base_uf = uf_seen;
        ctrl_read($urandom_range(2, 5));
        tick(2);
        check("t4_underflow", uf_seen - base_uf, 1);
        check("t4_tready", input_axis_tready, 1);

        // 5: streamed loopback 0x00..0x3F in chunks of 8
        clear_tx_model();
        base_uf  = uf_seen;
        base_ovf = ovf_seen;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 8; j++) push_in(8'(c * 8 + j));
            for (int j = 0; j < 8; j++) begin
                b = 8'(c * 8 + j);
                exp_out.push_back(b);
                wait_rxf_low("t5_wait_rxf");
                ctrl_read($urandom_range(1, 4));
                wait_txe_low("t5_wait_txe");
                ctrl_write(b, $urandom_range(1, 4));
            end
        end
        tick(4);
        check("t5_count", got_q.size(), 64);
        for (int i = 0; i < 64 && i < got_q.size(); i++) check("t5_data", got_q[i], exp_out[i]);
        check("t5_no_underflow", uf_seen - base_uf, 0);
        check("t5_no_overflow", ovf_seen - base_ovf, 0);

        // siwu_n strobe: one pulse, FIFOs untouched
        base_si = si_seen;
        ft245_siwu_n = 1'b0;
        tick(3);
        ft245_siwu_n = 1'b1;
        tick(LAT + 2);
        check("siwu_pulse", si_seen - base_si, 1);
        check("siwu_rxf", ft245_rxf_n, 1);
        check("siwu_tvalid", output_axis_tvalid, 0);

        // 6: reset during an active read
        push_in(8'h77);
        wait_rxf_low("t6_wait_rxf");
        ft245_rd_n = 1'b0;
        tick(LAT);
        check("t6_oe_before", ft245_d_oe, 1);
        check("t6_data_before", ft245_d_out, 8'h77);
        rst = 1'b1;
        #1;
        check("t6_oe_in_reset", ft245_d_oe, 0);
        tick();
        check("t6_rxf_reset", ft245_rxf_n, 1);
        check("t6_tvalid_reset", output_axis_tvalid, 0);
        check("t6_tready_reset", input_axis_tready, 0);
        rst = 1'b0;
        rx_model.delete();
        clear_tx_model();
        tick(LAT + 3);
        base_uf = uf_seen;
        push_in(8'h3C);
        ft245_rd_n = 1'b1;
        tick(LAT + 4);
        check("t6_no_pulse_on_rise", uf_seen - base_uf, 0);
        check("t6_byte_kept", ft245_rxf_n, 0);
        ctrl_read(3);
        check("t6_empty_after", ft245_rxf_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
